aud_i2s_player: RTL

- Downstream of AudDSP: consumes the 16-bit `o_dac_data` word and serializes it MSB-first onto the WM8731 DACDAT pin in I2S format.
- Runs entirely on the system clock `i_clk`. The codec's BCLK and DACLRCK arrive as asynchronous inputs; they are synchronized and edge-detected internally.
- Mono playback: a fresh sample is captured at every DACLRCK transition, so left and right each carry the current DSP word.

---
 rtl/aud_i2s_player.sv | 130 +++++++++++++
 1 files changed

// File: rtl/aud_i2s_player.sv
// aud_i2s_player: serializes the AudDSP sample MSB-first onto the WM8731
// DACDAT pin in I2S format. BCLK and DACLRCK are asynchronous codec clocks
// that are synchronized and edge-detected on the system clock.
`timescale 1ns/1ps
module aud_i2s_player #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_bclk,
   input  logic              i_daclrck,
   input  logic [DATA_W-1:0] i_dac_data,
   output logic              o_aud_dacdat,
   output logic              o_sample_req,
   output logic              o_busy
);

   localparam int CNT_W  = $clog2(DATA_W);
   localparam int WARM_W = $clog2(SYNC_STAGES + 2);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   shift_reg, shift_nxt;
   logic [CNT_W-1:0]    bit_cnt, cnt_nxt;
   logic                dat_nxt;

   logic [SYNC_STAGES-1:0] bclk_sync, lr_sync;
   logic                   bclk_hist, lr_hist;
   logic [WARM_W-1:0]      warm_cnt;
   logic                   lr_armed;
   logic                   bclk_s, lr_s;
   logic                   bclk_fall, lr_edge, capture;

   assign bclk_s = bclk_sync[SYNC_STAGES-1];
   assign lr_s   = lr_sync[SYNC_STAGES-1];

   // LR edges are only trusted once the sync chain and history flop hold the
   // real pin level, so a DACLRCK level present at reset release is no edge.
   assign lr_armed  = (warm_cnt == WARM_W'(SYNC_STAGES + 1));
   assign bclk_fall = bclk_hist & ~bclk_s;
   assign lr_edge   = lr_armed & (lr_hist ^ lr_s);
   assign capture   = lr_edge & i_en;

   // Synchronizer chains, history flops and post-reset warm-up counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
         bclk_hist <= 1'b0;
         lr_hist   <= 1'b0;
         warm_cnt  <= '0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i_bclk};
         lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i_daclrck};
         bclk_hist <= bclk_s;
         lr_hist   <= lr_s;
         if (!lr_armed)
            warm_cnt <= warm_cnt + 1'b1;
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state: a capture wins over a coincident BCLK fall, which gives the
   // one-BCLK I2S delay before the MSB.
   always_comb begin
      state_nxt = state;
      if (capture) begin
         state_nxt = ST_WAIT;
      end else if (bclk_fall) begin
         case (state)
            ST_WAIT: state_nxt = ST_SEND;
            ST_SEND: if (bit_cnt == '0) state_nxt = ST_IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   // Output/datapath next values: load on capture, present one bit per fall
   always_comb begin
      shift_nxt = shift_reg;
      cnt_nxt   = bit_cnt;
      dat_nxt   = o_aud_dacdat;
      if (capture) begin
         shift_nxt = i_dac_data;
         cnt_nxt   = CNT_W'(DATA_W - 1);
      end else if (bclk_fall) begin
         case (state)
            ST_WAIT: dat_nxt = shift_reg[DATA_W-1];
            ST_SEND: begin
               if (bit_cnt != '0) begin
                  shift_nxt = {shift_reg[DATA_W-2:0], 1'b0};
                  dat_nxt   = shift_reg[DATA_W-2];
                  cnt_nxt   = bit_cnt - 1'b1;
               end else begin
                  dat_nxt = 1'b0;
               end
            end
            default: dat_nxt = 1'b0;
         endcase
      end
   end

   // Registered datapath and outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shift_reg    <= '0;
         bit_cnt      <= '0;
         o_aud_dacdat <= 1'b0;
         o_sample_req <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         shift_reg    <= shift_nxt;
         bit_cnt      <= cnt_nxt;
         o_aud_dacdat <= dat_nxt;
         o_sample_req <= capture;
         o_busy       <= (state_nxt != ST_IDLE);
      end
   end

endmodule
